// File: rtl/cdb_pkg.sv
// Shared types and ROB-distance helpers for the common data bus broadcaster.
package cdb_pkg;

   localparam int NUM_FU  = 5;
   localparam int NUM_ROB = 8;
   localparam int NUM_PR  = 64;
   localparam int XLEN    = 64;
   localparam int FU_W    = $clog2(NUM_FU);
   localparam int ROB_W   = $clog2(NUM_ROB);
   localparam int PR_W    = $clog2(NUM_PR);
   localparam int DEST_W  = 5;

   typedef struct packed {
      logic              valid;
      logic [PR_W-1:0]   T_idx;
      logic [ROB_W-1:0]  ROB_idx;
      logic [DEST_W-1:0] dest_idx;
      logic [XLEN-1:0]   result;
   } CDB_SLOT_t;

   localparam CDB_SLOT_t CDB_SLOT_RESET = '0;

   typedef struct packed {
      logic [PR_W-1:0] T_idx;
   } CDB_RS_OUT_t;

   typedef struct packed {
      logic              done;
      logic [PR_W-1:0]   T_idx;
      logic [ROB_W-1:0]  ROB_idx;
      logic [DEST_W-1:0] dest_idx;
      logic [XLEN-1:0]   result;
   } FU_DONE_t;

   // Distance from base to idx around the ROB ring; wraps naturally at NUM_ROB.
   function automatic logic [ROB_W-1:0] rob_diff(input logic [ROB_W-1:0] idx,
                                                 input logic [ROB_W-1:0] base);
      return idx - base;
   endfunction

   function automatic logic rob_squashed(input logic             rollback_en,
                                         input logic [ROB_W-1:0] rollback_idx,
                                         input logic [ROB_W-1:0] diff,
                                         input logic [ROB_W-1:0] idx);
      return rollback_en && (diff >= rob_diff(idx, rollback_idx));
   endfunction

endpackage

// File: rtl/cdb_rr_arb.sv
// Round-robin picker: first set request scanning from ptr upward with wrap at N.
module cdb_rr_arb
   import cdb_pkg::*;
#(
   parameter int N = NUM_FU,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         hit,
   output logic [W-1:0] grant
);

   logic [W:0]   sum;
   logic [W-1:0] idx;

   // Scan from the far end so the entry closest to ptr is the last to assign.
   always_comb begin
      hit   = 1'b0;
      grant = '0;
      sum   = '0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (W + 1)'(k);
         if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
         idx = sum[W-1:0];
         if (req[idx]) begin
            hit   = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/cdb.sv
// Common data bus broadcaster: per-FU result slots, round-robin onto one bus.
// Optional same-cycle bypass of FU results is enabled by defining CDB_BYPASS_EN.
module cdb
   import cdb_pkg::*;
#(
   parameter int NUM_FU  = cdb_pkg::NUM_FU,
   parameter int NUM_ROB = cdb_pkg::NUM_ROB,
   parameter int NUM_PR  = cdb_pkg::NUM_PR,
   parameter int XLEN    = cdb_pkg::XLEN,
   localparam int FW = $clog2(NUM_FU),
   localparam int RW = $clog2(NUM_ROB),
   localparam int PW = $clog2(NUM_PR)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   rollback_en,
   input  logic [RW-1:0]          ROB_rollback_idx,
   input  logic [RW-1:0]          diff_ROB,
   input  logic [NUM_FU-1:0]      FU_done,
   input  logic [NUM_FU*PW-1:0]   FU_T_idx,
   input  logic [NUM_FU*RW-1:0]   FU_ROB_idx,
   input  logic [NUM_FU*5-1:0]    FU_dest_idx,
   input  logic [NUM_FU*XLEN-1:0] FU_result,
   output logic [NUM_FU-1:0]      FU_valid,
   output logic                   complete_en,
   output logic [PW-1:0]          CDB_T_idx,
   output logic [RW-1:0]          CDB_ROB_idx,
   output logic [4:0]             CDB_dest_idx,
   output logic [XLEN-1:0]        CDB_result
);

   FU_DONE_t    fu_in [NUM_FU];
   CDB_SLOT_t   slot  [NUM_FU];
   CDB_SLOT_t   bus_sel;
   CDB_RS_OUT_t rs_out;
   logic [FW-1:0]     rr_ptr, grant;
   logic [NUM_FU-1:0] slot_sq, in_sq, eligible, bypass_req, req;
   logic              any_eligible, hit, bypass;

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         fu_in[i].done     = FU_done[i];
         fu_in[i].T_idx    = FU_T_idx[i*PW +: PW];
         fu_in[i].ROB_idx  = FU_ROB_idx[i*RW +: RW];
         fu_in[i].dest_idx = FU_dest_idx[i*5 +: 5];
         fu_in[i].result   = FU_result[i*XLEN +: XLEN];
         slot_sq[i]  = rob_squashed(rollback_en, ROB_rollback_idx, diff_ROB, slot[i].ROB_idx);
         in_sq[i]    = rob_squashed(rollback_en, ROB_rollback_idx, diff_ROB, fu_in[i].ROB_idx);
         eligible[i] = slot[i].valid && !slot_sq[i];
      end
`ifdef CDB_BYPASS_EN
      bypass_req = FU_done & ~in_sq;
`else
      bypass_req = '0;
`endif
   end

   // Stored results always win; raw FU inputs only compete when no slot is eligible.
   assign any_eligible = |eligible;
   assign bypass       = !any_eligible;
   assign req          = any_eligible ? eligible : bypass_req;

   cdb_rr_arb #(.N(NUM_FU)) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .hit   (hit),
      .grant (grant)
   );

   always_comb begin
      complete_en = en && hit;
      bus_sel     = CDB_SLOT_RESET;
      if (complete_en) begin
         if (bypass) bus_sel = '{1'b1, fu_in[grant].T_idx, fu_in[grant].ROB_idx,
                                 fu_in[grant].dest_idx, fu_in[grant].result};
         else        bus_sel = slot[grant];
      end
      rs_out.T_idx = bus_sel.T_idx;
      CDB_T_idx    = rs_out.T_idx;
      CDB_ROB_idx  = bus_sel.ROB_idx;
      CDB_dest_idx = bus_sel.dest_idx;
      CDB_result   = bus_sel.result;
      for (int i = 0; i < NUM_FU; i++)
         FU_valid[i] = en && (!slot[i].valid || slot_sq[i] ||
                              (hit && !bypass && grant == FW'(i)));
   end

   // NOTE: slots are few and narrow, so they are plain flops reset as a whole; a
   // RAM-style array without reset would leave stale valid bits after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FU; i++) slot[i] <= CDB_SLOT_RESET;
         rr_ptr <= '0;
      end else if (en) begin
         // NOTE: state updates are non-blocking so every slot sees this cycle's grant.
         for (int i = 0; i < NUM_FU; i++) begin
            if (FU_done[i] && FU_valid[i] && !in_sq[i] &&
                !(hit && bypass && grant == FW'(i)))
               slot[i] <= '{1'b1, fu_in[i].T_idx, fu_in[i].ROB_idx,
                            fu_in[i].dest_idx, fu_in[i].result};
            else if ((hit && !bypass && grant == FW'(i)) || slot_sq[i])
               slot[i].valid <= 1'b0;
         end
         if (hit) rr_ptr <= (grant == FW'(NUM_FU - 1)) ? '0 : grant + 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb.sv
// Directed self-checking bench for cdb: latency, fairness, squash, freeze, reset.
module tb_cdb;

   localparam int NF = 5;
   localparam int PW = 6;
   localparam int RW = 3;
   localparam int XL = 64;

   logic              clock, reset, en, rollback_en;
   logic [RW-1:0]     ROB_rollback_idx, diff_ROB;
   logic [NF-1:0]     FU_done, FU_valid;
   logic [NF*PW-1:0]  FU_T_idx;
   logic [NF*RW-1:0]  FU_ROB_idx;
   logic [NF*5-1:0]   FU_dest_idx;
   logic [NF*XL-1:0]  FU_result;
   logic              complete_en;
   logic [PW-1:0]     CDB_T_idx;
   logic [RW-1:0]     CDB_ROB_idx;
   logic [4:0]        CDB_dest_idx;
   logic [XL-1:0]     CDB_result;

   int checks = 0;
   int errors = 0;

   cdb dut (
      .clock(clock), .reset(reset), .en(en), .rollback_en(rollback_en),
      .ROB_rollback_idx(ROB_rollback_idx), .diff_ROB(diff_ROB),
      .FU_done(FU_done), .FU_T_idx(FU_T_idx), .FU_ROB_idx(FU_ROB_idx),
      .FU_dest_idx(FU_dest_idx), .FU_result(FU_result), .FU_valid(FU_valid),
      .complete_en(complete_en), .CDB_T_idx(CDB_T_idx), .CDB_ROB_idx(CDB_ROB_idx),
      .CDB_dest_idx(CDB_dest_idx), .CDB_result(CDB_result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Offering a result to an FU whose FU_valid is low breaks the issue protocol.
   always @(negedge clock)
      if (!reset && en && |(FU_done & ~FU_valid))
         $error("protocol: FU_done=%b FU_valid=%b", FU_done, FU_valid);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fu(input int i, input int t, input int rob, input int dst,
                         input logic [63:0] res);
      FU_done[i]               = 1'b1;
      FU_T_idx[i*PW +: PW]     = PW'(t);
      FU_ROB_idx[i*RW +: RW]   = RW'(rob);
      FU_dest_idx[i*5 +: 5]    = 5'(dst);
      FU_result[i*XL +: XL]    = res;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; rollback_en = 1'b0;
      ROB_rollback_idx = '0; diff_ROB = '0;
      FU_done = '0; FU_T_idx = '0; FU_ROB_idx = '0; FU_dest_idx = '0; FU_result = '0;
      #3;
      check("rst_complete_en", complete_en, 0);
      check("rst_T_idx", CDB_T_idx, 0);
      check("rst_result", CDB_result, 0);
      check("rst_FU_valid", FU_valid, 5'h1F);
      tick();
      reset = 1'b0;

      // Single result on FU 2: one-cycle latency through its slot.
      set_fu(2, 17, 3, 9, 64'hDEAD_BEEF_0123_4567);
      #2;
`ifndef CDB_BYPASS_EN
      check("lat_same_cycle_idle", complete_en, 0);
`endif
      tick();
      FU_done = '0;
`ifndef CDB_BYPASS_EN
      #2;
      check("lat_complete_en", complete_en, 1);
      check("lat_T_idx", CDB_T_idx, 17);
      check("lat_ROB_idx", CDB_ROB_idx, 3);
      check("lat_dest_idx", CDB_dest_idx, 9);
      check("lat_result", CDB_result, 64'hDEAD_BEEF_0123_4567);
      check("lat_FU_valid", FU_valid, 5'h1F);
      tick();
`endif
      #2;
      check("lat_slot_empty", complete_en, 0);

      // Contention on FUs 0, 1, 4 with rr_ptr at 0.
      tick();
      pulse_reset();
      set_fu(0, 1, 0, 1, 64'd100);
      set_fu(1, 2, 1, 2, 64'd101);
      set_fu(4, 5, 4, 5, 64'd104);
      tick();
      FU_done = '0;
      #2;
      check("rr0_T_idx", CDB_T_idx, 1);
      check("rr0_FU_valid", FU_valid, 5'b01101);
      tick(); #2;
      check("rr1_T_idx", CDB_T_idx, 2);
      check("rr1_FU_valid", FU_valid, 5'b01111);
      tick(); #2;
      check("rr2_T_idx", CDB_T_idx, 5);
      check("rr2_complete_en", complete_en, 1);
      check("rr2_FU_valid", FU_valid, 5'h1F);
      tick(); #2;
      check("rr_done_idle", complete_en, 0);

      // FU 1 streams one result per cycle: load beats clear in the same slot.
      tick();
      for (int k = 0; k <= 6; k++) begin
         FU_done = '0;
         if (k < 6) set_fu(1, 20 + k, k, 1, 64'(k));
         #2;
         if (k > 0) begin
            check("stream_complete_en", complete_en, 1);
            check("stream_T_idx", CDB_T_idx, 64'(20 + k - 1));
            check("stream_FU_valid1", FU_valid[1], 1);
         end
         tick();
      end
      #2;
      check("stream_drained", complete_en, 0);

      // Squash: rollback at ROB 5 spanning 2 removes ROB 5 and 7, keeps ROB 2.
      tick();
      set_fu(2, 50, 5, 2, 64'd50);
      set_fu(3, 51, 7, 3, 64'd51);
      set_fu(4, 52, 2, 4, 64'd52);
      tick();
      FU_done = '0;
      rollback_en = 1'b1; ROB_rollback_idx = 3'd5; diff_ROB = 3'd2;
      set_fu(0, 53, 6, 7, 64'd53);
      #2;
      check("sq_complete_en", complete_en, 1);
      check("sq_ROB_idx", CDB_ROB_idx, 2);
      check("sq_T_idx", CDB_T_idx, 52);
      check("sq_FU_valid", FU_valid, 5'h1F);
      tick();
      FU_done = '0; rollback_en = 1'b0; ROB_rollback_idx = '0; diff_ROB = '0;
      #2;
      check("sq_all_cleared", complete_en, 0);

      // Freeze with all slots full, then resume in rr order from pointer 0.
      tick();
      for (int i = 0; i < NF; i++) set_fu(i, 30 + i, i, i, 64'(1000 + i));
      tick();
      FU_done = '0;
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         check("frz_complete_en", complete_en, 0);
         check("frz_FU_valid", FU_valid, 0);
         check("frz_T_idx", CDB_T_idx, 0);
         check("frz_result", CDB_result, 0);
         tick();
      end
      en = 1'b1;
      for (int k = 0; k < NF; k++) begin
         #2;
         check("resume_T_idx", CDB_T_idx, 64'(30 + k));
         check("resume_result", CDB_result, 64'(1000 + k));
         tick();
      end
      #2;
      check("resume_drained", complete_en, 0);

      // Reset while a result sits in a slot discards it at once.
      tick();
      set_fu(0, 60, 1, 1, 64'd60);
      tick();
      FU_done = '0;
      #2;
      check("mid_before_reset", complete_en, 1);
      reset = 1'b1;
      #1;
      check("mid_reset_complete_en", complete_en, 0);
      check("mid_reset_FU_valid", FU_valid, 5'h1F);
      tick();
      reset = 1'b0;
      #2;
      check("mid_after_reset", complete_en, 0);

      // FU 3 alone on empty slots: same cycle with bypass, next cycle without.
      tick();
      set_fu(3, 40, 1, 3, 64'd40);
      #2;
`ifdef CDB_BYPASS_EN
      check("byp_complete_en", complete_en, 1);
      check("byp_T_idx", CDB_T_idx, 40);
      tick();
      FU_done = '0;
      #2;
      check("byp_slot_empty", complete_en, 0);
      check("byp_FU_valid", FU_valid, 5'h1F);
`else
      check("nobyp_same_cycle", complete_en, 0);
      tick();
      FU_done = '0;
      #2;
      check("nobyp_complete_en", complete_en, 1);
      check("nobyp_T_idx", CDB_T_idx, 40);
      tick(); #2;
      check("nobyp_drained", complete_en, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
